fm_add_bram_adder: RTL and testbench

//  Element-wise feature-map adder between the two on-chip BRAM banks.

---
 rtl/fm_add_pkg.sv | 21 ++
 rtl/fm_add_bram_adder_if.sv | 14 +
 rtl/fm_add_sat_lane.sv | 26 ++
 rtl/fm_add_bram_adder.sv | 143 ++++++++++++++
 tb/tb_fm_add_bram_adder.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fm_add_pkg.sv
// rtl/fm_add_pkg.sv - shared types and helpers for the fm_add BRAM movers
package fm_add_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int ELEM_WIDTH_DEF = 16;

    // Counter add that pins at all-ones instead of wrapping.
    function automatic logic [15:0] sat_cnt_add(input logic [15:0] cnt, input logic [15:0] inc);
        logic [16:0] s;
        s = {1'b0, cnt} + {1'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/fm_add_bram_adder_if.sv
// rtl/fm_add_bram_adder_if.sv - single-port BRAM bank interface
interface fm_add_bank_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 256
);
    logic                  en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;

    modport master (output en, output we, output addr, output din, input dout);
    modport slave  (input en, input we, input addr, input din, output dout);
endinterface

// File: rtl/fm_add_sat_lane.sv
// rtl/fm_add_sat_lane.sv - signed saturating add of one lane with sat flag
module fm_add_sat_lane #(
    parameter int ELEM_WIDTH = 16
) (
    input  logic [ELEM_WIDTH-1:0] a,
    input  logic [ELEM_WIDTH-1:0] b,
    output logic [ELEM_WIDTH-1:0] sum,
    output logic                  sat
);
    localparam logic [ELEM_WIDTH-1:0] MAX_VAL = {1'b0, {(ELEM_WIDTH-1){1'b1}}};
    localparam logic [ELEM_WIDTH-1:0] MIN_VAL = {1'b1, {(ELEM_WIDTH-1){1'b0}}};

    logic [ELEM_WIDTH:0] full;

    always_comb begin
        full = {a[ELEM_WIDTH-1], a} + {b[ELEM_WIDTH-1], b};
        // Overflow shows as the extra sign bit disagreeing with the result sign.
        sat  = full[ELEM_WIDTH] ^ full[ELEM_WIDTH-1];
        if (!sat)
            sum = full[ELEM_WIDTH-1:0];
        else if (full[ELEM_WIDTH])
            sum = MIN_VAL;
        else
            sum = MAX_VAL;
    end
endmodule

// File: rtl/fm_add_bram_adder.sv
// rtl/fm_add_bram_adder.sv - element-wise saturating adder between BRAM banks
module fm_add_bram_adder
    import fm_add_pkg::*;
#(
    parameter int FM_COL          = 4,
    parameter int FM_ROW          = 5,
    parameter int BRAM_DATA_WIDTH = FM_COL * 64,
    parameter int BRAM_DEPTH      = 64,
    parameter int BRAM_ADDR_WIDTH = $clog2(BRAM_DEPTH),
    parameter int ELEM_WIDTH      = ELEM_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       module_en,
    input  logic [BRAM_ADDR_WIDTH-1:0] bram_begin_addr,
    input  logic                       dst_sel,
    output logic                       module_done,
    output logic                       busy,
    output logic [15:0]                sat_cnt,
    fm_add_bank_if.master              bram0,
    fm_add_bank_if.master              bram1
);
    localparam int LANES = BRAM_DATA_WIDTH / ELEM_WIDTH;
    localparam int ROW_W = $clog2(FM_ROW + 1);
    localparam int POP_W = $clog2(LANES + 1);

    state_t                     state;
    logic [BRAM_ADDR_WIDTH-1:0] begin_r;
    logic                       dst_r;
    logic [ROW_W-1:0]           row_r;
    logic [BRAM_DATA_WIDTH-1:0] sum_r;
    logic [BRAM_DATA_WIDTH-1:0] lane_sum;
    logic [LANES-1:0]           lane_sat;
    logic [POP_W-1:0]           sat_pop;
    logic [BRAM_ADDR_WIDTH-1:0] cur_addr;

    logic                       b0_en, b0_we, b1_en, b1_we;
    logic [BRAM_ADDR_WIDTH-1:0] b0_addr, b1_addr;

    // Wraps modulo the bank depth by truncation.
    assign cur_addr = begin_r + BRAM_ADDR_WIDTH'(row_r);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fm_add_sat_lane #(.ELEM_WIDTH(ELEM_WIDTH)) u_lane (
            .a   (bram0.dout[i*ELEM_WIDTH +: ELEM_WIDTH]),
            .b   (bram1.dout[i*ELEM_WIDTH +: ELEM_WIDTH]),
            .sum (lane_sum[i*ELEM_WIDTH +: ELEM_WIDTH]),
            .sat (lane_sat[i])
        );
    end

    always_comb begin
        sat_pop = '0;
        for (int i = 0; i < LANES; i++)
            sat_pop = sat_pop + POP_W'(lane_sat[i]);
    end

    assign bram0.en   = b0_en;
    assign bram0.we   = b0_we;
    assign bram0.addr = b0_addr;
    assign bram0.din  = b0_we ? sum_r : '0;
    assign bram1.en   = b1_en;
    assign bram1.we   = b1_we;
    assign bram1.addr = b1_addr;
    assign bram1.din  = b1_we ? sum_r : '0;

    // Bank controls are registered for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            begin_r     <= '0;
            dst_r       <= 1'b0;
            row_r       <= '0;
            sum_r       <= '0;
            sat_cnt     <= '0;
            busy        <= 1'b0;
            module_done <= 1'b0;
            b0_en       <= 1'b0;
            b0_we       <= 1'b0;
            b0_addr     <= '0;
            b1_en       <= 1'b0;
            b1_we       <= 1'b0;
            b1_addr     <= '0;
        end else begin
            module_done <= 1'b0;
            b0_en       <= 1'b0;
            b0_we       <= 1'b0;
            b0_addr     <= '0;
            b1_en       <= 1'b0;
            b1_we       <= 1'b0;
            b1_addr     <= '0;
            case (state)
                IDLE: begin
                    if (module_en) begin
                        begin_r <= bram_begin_addr;
                        dst_r   <= dst_sel;
                        sat_cnt <= '0;
                        row_r   <= '0;
                        busy    <= 1'b1;
                        state   <= RD;
                        b0_en   <= 1'b1;
                        b1_en   <= 1'b1;
                        b0_addr <= bram_begin_addr;
                        b1_addr <= bram_begin_addr;
                    end
                end
                RD: state <= WAIT;
                WAIT: begin
                    sum_r   <= lane_sum;
                    sat_cnt <= sat_cnt_add(sat_cnt, 16'(sat_pop));
                    state   <= WR;
                    if (dst_r) begin
                        b1_en   <= 1'b1;
                        b1_we   <= 1'b1;
                        b1_addr <= cur_addr;
                    end else begin
                        b0_en   <= 1'b1;
                        b0_we   <= 1'b1;
                        b0_addr <= cur_addr;
                    end
                end
                WR: begin
                    row_r <= row_r + ROW_W'(1);
                    if (row_r == ROW_W'(FM_ROW - 1)) begin
                        state       <= DONE;
                        module_done <= 1'b1;
                    end else begin
                        state   <= RD;
                        b0_en   <= 1'b1;
                        b1_en   <= 1'b1;
                        b0_addr <= cur_addr + BRAM_ADDR_WIDTH'(1);
                        b1_addr <= cur_addr + BRAM_ADDR_WIDTH'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fm_add_bram_adder.sv
// tb/tb_fm_add_bram_adder.sv - self-checking bench for fm_add_bram_adder
module tb_fm_add_bram_adder;
    import fm_add_pkg::*;

    localparam int AW    = 6;
    localparam int DW    = 256;
    localparam int DEPTH = 64;
    localparam int LANES = 16;
    localparam int NROW  = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          module_en = 1'b0;
    logic [AW-1:0] bram_begin_addr = '0;
    logic          dst_sel = 1'b0;
    logic          module_done, busy;
    logic [15:0]   sat_cnt;

    fm_add_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b0 ();
    fm_add_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1 ();

    fm_add_bram_adder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .module_en       (module_en),
        .bram_begin_addr (bram_begin_addr),
        .dst_sel         (dst_sel),
        .module_done     (module_done),
        .busy            (busy),
        .sat_cnt         (sat_cnt),
        .bram0           (b0),
        .bram1           (b1)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] img0 [DEPTH];
    logic [DW-1:0] img1 [DEPTH];
    logic [DW-1:0] exp0 [DEPTH];
    logic [DW-1:0] exp1 [DEPTH];
    logic          load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            mem0 <= img0;
            mem1 <= img1;
        end else begin
            if (b0.en) begin
                if (b0.we) mem0[b0.addr] <= b0.din;
                else       b0.dout <= mem0[b0.addr];
            end
            if (b1.en) begin
                if (b1.we) mem1[b1.addr] <= b1.din;
                else       b1.dout <= mem1[b1.addr];
            end
        end
    end

    int mon_err = 0;
    int wr1_cnt = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (((b0.en && b0.we) || (b1.en && b1.we)) && ((b0.en && !b0.we) || (b1.en && !b1.we)))
                mon_err++;
            if (dut.state == IDLE && busy)
                mon_err++;
            if (dut.state != RD && dut.state != WR &&
                (b0.en || b0.we || (|b0.addr) || (|b0.din) || b1.en || b1.we || (|b1.addr) || (|b1.din)))
                mon_err++;
            if (b1.we) wr1_cnt++;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_row();
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [DW-1:0] fill_row(input logic [15:0] val);
        logic [DW-1:0] v;
        for (int l = 0; l < LANES; l++) v[l*16 +: 16] = val;
        return v;
    endfunction

    task automatic fill(input int mode);
        for (int r = 0; r < DEPTH; r++) begin
            case (mode)
                0: begin
                    img0[r] = fill_row(16'(r));
                    img1[r] = fill_row(16'(2 * r));
                end
                1: begin
                    for (int l = 0; l < LANES; l++) begin
                        int s0, s1;
                        s0 = int'($urandom_range(0, 2000)) - 1000;
                        s1 = int'($urandom_range(0, 2000)) - 1000;
                        img0[r][l*16 +: 16] = 16'(s0);
                        img1[r][l*16 +: 16] = 16'(s1);
                    end
                    img0[r][15:0]  = 16'h7FFF;
                    img1[r][15:0]  = 16'h0001;
                    img0[r][31:16] = 16'h8000;
                    img1[r][31:16] = 16'hFFFF;
                end
                default: begin
                    img0[r] = rand_row();
                    img1[r] = rand_row();
                end
            endcase
        end
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    // Reference: plain integer sums clamped to the 16-bit signed range.
    task automatic model(input logic [AW-1:0] beg, input logic dst, output int sat);
        sat = 0;
        img0 = mem0;
        img1 = mem1;
        exp0 = mem0;
        exp1 = mem1;
        for (int r = 0; r < NROW; r++) begin
            int a;
            a = (int'(beg) + r) % DEPTH;
            for (int l = 0; l < LANES; l++) begin
                logic signed [15:0] x, y;
                int s;
                x = img0[a][l*16 +: 16];
                y = img1[a][l*16 +: 16];
                s = int'(x) + int'(y);
                if (s > 32767)       begin s = 32767;  sat++; end
                else if (s < -32768) begin s = -32768; sat++; end
                if (dst) exp1[a][l*16 +: 16] = 16'(s);
                else     exp0[a][l*16 +: 16] = 16'(s);
            end
        end
    endtask

    task automatic do_run(input logic [AW-1:0] beg, input logic dst, input int p1, input int p2,
                          input int rst_at, output int done_cyc, output int done_n, output int busy_bad);
        @(posedge clk); #1;
        bram_begin_addr = beg;
        dst_sel = dst;
        module_en = 1'b1;
        done_cyc = -1;
        done_n = 0;
        busy_bad = 0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            module_en = (c == p1 || c == p2);
            bram_begin_addr = module_en ? AW'($urandom) : beg;
            dst_sel = module_en ? ~dst : dst;
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("async reset outputs",
                    {53'd0, busy, module_done, b0.en, b0.we, b1.en, b1.we,
                     |b0.addr, |b1.addr, |b0.din, |b1.din, |sat_cnt}, 64'd0);
            end
            if (rst_at > 0 && c == rst_at + 2) rst_n = 1'b1;
            if (module_done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (rst_at == 0 && busy !== (c <= 3 * NROW + 1)) busy_bad++;
        end
        module_en = 1'b0;
    endtask

    typedef struct {
        int            mode;
        logic [AW-1:0] beg;
        logic          dst;
        int            p1;
        int            p2;
        int            exp_done;
        int            exp_sat;
    } vec_t;

    task automatic check_banks(input string tag);
        int bad0, bad1;
        bad0 = 0;
        bad1 = 0;
        for (int r = 0; r < DEPTH; r++) begin
            if (mem0[r] !== exp0[r]) bad0++;
            if (mem1[r] !== exp1[r]) bad1++;
        end
        chk({tag, " bram0 bad rows"}, 64'(bad0), 64'd0);
        chk({tag, " bram1 bad rows"}, 64'(bad1), 64'd0);
    endtask

    initial begin
        vec_t vecs [5];
        int   msat, dcyc, dn, bbad, me0, w10;

        vecs[0] = '{mode: 0, beg: 6'd0,  dst: 1'b1, p1: -1, p2: -1, exp_done: 16, exp_sat: 0};
        vecs[1] = '{mode: 1, beg: 6'd10, dst: 1'b1, p1: -1, p2: -1, exp_done: 16, exp_sat: 10};
        vecs[2] = '{mode: 2, beg: 6'd62, dst: 1'b0, p1: -1, p2: -1, exp_done: 16, exp_sat: -1};
        vecs[3] = '{mode: 2, beg: 6'd20, dst: 1'b1, p1: 2,  p2: 9,  exp_done: 16, exp_sat: -1};
        vecs[4] = '{mode: 1, beg: 6'd33, dst: 1'b0, p1: -1, p2: -1, exp_done: 16, exp_sat: 10};

        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs",
            {54'd0, busy, module_done, b0.en, b1.en, b0.we, b1.we, |b0.addr, |b1.addr, |sat_cnt, 1'b0}, 64'd0);
        chk("reset state", 64'(dut.state), 64'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            fill(vecs[i].mode);
            model(vecs[i].beg, vecs[i].dst, msat);
            me0 = mon_err;
            w10 = wr1_cnt;
            do_run(vecs[i].beg, vecs[i].dst, vecs[i].p1, vecs[i].p2, 0, dcyc, dn, bbad);
            chk($sformatf("v%0d done cycle", i), 64'(dcyc), 64'(vecs[i].exp_done));
            chk($sformatf("v%0d done count", i), 64'(dn), 64'd1);
            chk($sformatf("v%0d busy window", i), 64'(bbad), 64'd0);
            chk($sformatf("v%0d sat_cnt model", i), 64'(sat_cnt), 64'(msat));
            if (vecs[i].exp_sat >= 0)
                chk($sformatf("v%0d sat_cnt const", i), 64'(sat_cnt), 64'(vecs[i].exp_sat));
            check_banks($sformatf("v%0d", i));
            chk($sformatf("v%0d invariants", i), 64'(mon_err - me0), 64'd0);
            if (!vecs[i].dst)
                chk($sformatf("v%0d bram1 writes", i), 64'(wr1_cnt - w10), 64'd0);
            if (vecs[i].mode == 0)
                chk($sformatf("v%0d row4 lane7", i), 64'(mem1[4][7*16 +: 16]), 64'd12);
        end

        // Reset in the middle of a run, then a clean run afterwards.
        fill(2);
        do_run(6'd40, 1'b1, -1, -1, 7, dcyc, dn, bbad);
        chk("reset run done count", 64'(dn), 64'd0);
        chk("reset run state", 64'(dut.state), 64'(IDLE));
        model(6'd40, 1'b1, msat);
        me0 = mon_err;
        do_run(6'd40, 1'b1, -1, -1, 0, dcyc, dn, bbad);
        chk("post-reset done cycle", 64'(dcyc), 64'd16);
        chk("post-reset done count", 64'(dn), 64'd1);
        chk("post-reset sat_cnt", 64'(sat_cnt), 64'(msat));
        check_banks("post-reset");
        chk("post-reset invariants", 64'(mon_err - me0), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
